// File: rtl/act_requant_stage_if.sv
// Stream and bias-memory port bundle for the activation/requantization stage.
// The stage is the slave: it consumes accumulator words and drives the bias read address.
interface act_requant_stage_if #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 128,
    parameter int N_HIDDEN = 64,
    parameter int N_LAYERS = 3
);
    localparam int ACC_W  = 2 * DATA_W + $clog2(N_IN);
    localparam int ADDR_W = $clog2(N_LAYERS * N_HIDDEN);

    logic signed [ACC_W-1:0]  in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic        [ADDR_W-1:0] bmem_raddr;
    logic signed [DATA_W-1:0] bmem_rdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  bmem_raddr,
        output bmem_rdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output bmem_raddr,
        input  bmem_rdata
    );
endinterface

// File: rtl/act_requant_stage.sv
// Post-MAC stage: adds a per-neuron bias, round-shifts, optional ReLU, saturates
// to DATA_W and assembles one layer's results into a parallel activation vector.
module act_requant_stage #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 128,
    parameter int N_HIDDEN = 64,
    parameter int N_LAYERS = 3,
    parameter int FRAC_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    act_requant_stage_if.slave           bus,
    input  logic [$clog2(N_LAYERS)-1:0]  layer_idx,
    input  logic                         relu_en,
    input  logic                         start_layer,
    output logic [N_HIDDEN*DATA_W-1:0]   out_vec,
    output logic                         vec_valid,
    output logic [$clog2(N_HIDDEN):0]    sat_count,
    output logic                         busy
);
    localparam int ACC_W  = 2 * DATA_W + $clog2(N_IN);
    localparam int SUM_W  = ACC_W + 2;
    localparam int IDX_W  = $clog2(N_HIDDEN);
    localparam int ADDR_W = $clog2(N_LAYERS * N_HIDDEN);
    localparam int SAT_W  = $clog2(N_HIDDEN) + 1;

    localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;
    localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1) << (FRAC_W - 1);
    localparam logic [IDX_W-1:0]        LAST  = IDX_W'(N_HIDDEN - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t                          state;
    logic                            relu_q;
    logic [IDX_W-1:0]                idx;
    logic [N_HIDDEN-1:0][DATA_W-1:0] vec_q;

    logic signed [SUM_W-1:0] in_ext;
    logic signed [SUM_W-1:0] bias_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] rnd;
    logic signed [SUM_W-1:0] clipped;
    logic        [DATA_W-1:0] result;
    logic                     sat_hit;

    assign out_vec = vec_q;

    // Bias add, round-half-up shift, ReLU then saturation at full precision.
    always_comb begin
        in_ext   = {{2{bus.in_data[ACC_W-1]}}, bus.in_data};
        bias_ext = {{(SUM_W-DATA_W){bus.bmem_rdata[DATA_W-1]}}, bus.bmem_rdata} << FRAC_W;
        sum      = in_ext + bias_ext;
        rnd      = (sum + ROUND) >>> FRAC_W;
        clipped  = rnd;
        sat_hit  = 1'b0;
        if (relu_q && rnd[SUM_W-1]) begin
            clipped = '0;
        end
        if (clipped > MAX_V) begin
            clipped = MAX_V;
            sat_hit = 1'b1;
        end else if (clipped < MIN_V) begin
            clipped = MIN_V;
            sat_hit = 1'b1;
        end
        result = clipped[DATA_W-1:0];
    end

    // Layer collection FSM; start_layer restarts from any state and wins over an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            relu_q         <= 1'b0;
            idx            <= '0;
            sat_count      <= '0;
            vec_valid      <= 1'b0;
            busy           <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.bmem_raddr <= '0;
            vec_q          <= '0;
        end else if (start_layer) begin
            state          <= PRIME;
            relu_q         <= relu_en;
            idx            <= '0;
            sat_count      <= '0;
            vec_valid      <= 1'b0;
            busy           <= 1'b1;
            bus.in_ready   <= 1'b0;
            bus.bmem_raddr <= ADDR_W'(layer_idx) * ADDR_W'(N_HIDDEN);
        end else begin
            case (state)
                PRIME: begin
                    state        <= RUN;
                    bus.in_ready <= 1'b1;
                end
                RUN: begin
                    if (bus.in_valid && bus.in_ready) begin
                        vec_q[idx] <= result;
                        sat_count  <= sat_count + SAT_W'(sat_hit);
                        if (idx == LAST) begin
                            state        <= DONE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            vec_valid    <= 1'b1;
                        end else begin
                            idx            <= idx + IDX_W'(1);
                            bus.bmem_raddr <= bus.bmem_raddr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_act_requant_stage.sv
// Self-checking bench for act_requant_stage with a bias memory model and an
// arithmetic reference for the requantization of each neuron.
module tb_act_requant_stage;
    localparam int DATA_W   = 16;
    localparam int N_IN     = 128;
    localparam int N_HIDDEN = 64;
    localparam int N_LAYERS = 3;
    localparam int FRAC_W   = 8;
    localparam int ACC_W    = 2 * DATA_W + $clog2(N_IN);
    localparam int DEPTH    = N_LAYERS * N_HIDDEN;
    localparam int BUDGET   = 2000;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [1:0]                 layer_idx;
    logic                       relu_en;
    logic                       start_layer;
    logic [N_HIDDEN*DATA_W-1:0] out_vec;
    logic                       vec_valid;
    logic [6:0]                 sat_count;
    logic                       busy;

    act_requant_stage_if #(.DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_LAYERS(N_LAYERS)) bus ();

    act_requant_stage #(
        .DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN), .N_LAYERS(N_LAYERS), .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .layer_idx(layer_idx),
        .relu_en(relu_en),
        .start_layer(start_layer),
        .out_vec(out_vec),
        .vec_valid(vec_valid),
        .sat_count(sat_count),
        .busy(busy)
    );

    logic signed [DATA_W-1:0] bias_mem [DEPTH];
    assign bus.bmem_rdata = bias_mem[bus.bmem_raddr];

    int     checks = 0;
    int     failures = 0;
    longint stim [N_HIDDEN];
    int     exp_vec [N_HIDDEN];
    int     exp_sat;
    int     addr_log [$];

    always #5 clk = ~clk;

    // Floor division for a positive divisor.
    function automatic longint floor_div(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // One neuron: bias add, round half toward +inf, ReLU, saturate.
    function automatic int ref_val(longint din, longint bias, bit relu, output bit sat);
        longint s, r, hi, lo;
        hi  = (longint'(1) << (DATA_W - 1)) - 1;
        lo  = -(longint'(1) << (DATA_W - 1));
        s   = din + bias * (longint'(1) << FRAC_W);
        r   = floor_div(s + (longint'(1) << (FRAC_W - 1)), longint'(1) << FRAC_W);
        sat = 1'b0;
        if (relu && r < 0) r = 0;
        if (r > hi) begin r = hi; sat = 1'b1; end
        else if (r < lo) begin r = lo; sat = 1'b1; end
        return int'(r);
    endfunction

    task automatic build_expected(input int layer, input bit relu);
        bit s;
        exp_sat = 0;
        for (int i = 0; i < N_HIDDEN; i++) begin
            exp_vec[i] = ref_val(stim[i], longint'(bias_mem[layer*N_HIDDEN + i]), relu, s);
            exp_sat += int'(s);
        end
    endtask

    task automatic fill_small();
        for (int i = 0; i < N_HIDDEN; i++) stim[i] = longint'($signed($urandom)) >>> 9;
    endtask

    task automatic fill_mixed();
        for (int i = 0; i < N_HIDDEN; i++) begin
            stim[i] = longint'($signed($urandom));
            if ($urandom_range(1) == 1) stim[i] = stim[i] * 64;
        end
    endtask

    function automatic int elem(int i);
        logic signed [DATA_W-1:0] v;
        v = out_vec[i*DATA_W +: DATA_W];
        return int'(v);
    endfunction

    // Start pulse applied on one edge; returns #1 after that edge (cycle 1).
    task automatic pulse_start(input int layer, input bit relu);
        layer_idx   = 2'(layer);
        relu_en     = relu;
        start_layer = 1'b1;
        @(posedge clk); #1;
        start_layer = 1'b0;
    endtask

    // Feeds stim words; in_valid is also raised while in_ready is low to confirm it is ignored.
    task automatic stream(input int gap_pct, input int max_acc, output int cycles, output bit timed_out);
        int k = 0;
        cycles = 1;
        timed_out = 1'b0;
        addr_log.delete();
        while (1) begin
            if (vec_valid || k >= max_acc) break;
            if (cycles > BUDGET) begin timed_out = 1'b1; break; end
            bus.in_valid = (int'($urandom_range(99)) >= gap_pct) || !bus.in_ready;
            if (bus.in_valid && bus.in_ready && k < N_HIDDEN) bus.in_data = stim[k][ACC_W-1:0];
            else bus.in_data = ACC_W'({$urandom, $urandom});
            if (bus.in_valid && bus.in_ready) begin
                addr_log.push_back(int'(bus.bmem_raddr));
                k++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (vec_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_vec_valid got=%b exp=0", vec_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sat_count !== 7'd0) begin failures++; $display("[TB] FAIL reset_sat got=%0d exp=0", sat_count); end
        checks++; if (bus.bmem_raddr !== 8'd0) begin failures++; $display("[TB] FAIL reset_raddr got=%0d exp=0", bus.bmem_raddr); end
        checks++; if (out_vec !== '0) begin failures++; $display("[TB] FAIL reset_out_vec got=%h exp=0", out_vec); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc; bit to;
        fill_small();
        stim[0] = 4736;
        bias_mem[0] = 16'sd1;
        build_expected(0, 1'b0);
        pulse_start(0, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy got=%b exp=1", busy); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_prime_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.bmem_raddr !== 8'd0) begin failures++; $display("[TB] FAIL basic_raddr got=%0d exp=0", bus.bmem_raddr); end
        stream(0, N_HIDDEN, cyc, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL basic_timeout got=%0d cycles exp=vec_valid", cyc); end
        checks++; if (cyc !== N_HIDDEN + 2) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", cyc, N_HIDDEN + 2); end
        checks++; if (elem(0) !== 20) begin failures++; $display("[TB] FAIL basic_elem0 got=%0d exp=20", elem(0)); end
        for (int i = 0; i < N_HIDDEN; i++) begin
            checks++; if (elem(i) !== exp_vec[i]) begin failures++; $display("[TB] FAIL basic_elem[%0d] got=%0d exp=%0d", i, elem(i), exp_vec[i]); end
        end
        checks++; if (sat_count !== 7'd0) begin failures++; $display("[TB] FAIL basic_sat got=%0d exp=0", sat_count); end
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_done got=busy%b/ready%b exp=busy0/ready0", busy, bus.in_ready); end
    endtask

    task automatic test_relu();
        int cyc; bit to;
        fill_small();
        stim[0] = -1000;
        bias_mem[N_HIDDEN] = 16'sd0;
        for (int pass = 0; pass < 2; pass++) begin
            build_expected(1, pass[0]);
            pulse_start(1, pass[0]);
            checks++; if (vec_valid !== 1'b0) begin failures++; $display("[TB] FAIL relu_vv_clear got=%b exp=0", vec_valid); end
            checks++; if (bus.bmem_raddr !== 8'(N_HIDDEN)) begin failures++; $display("[TB] FAIL relu_raddr got=%0d exp=%0d", bus.bmem_raddr, N_HIDDEN); end
            stream(0, N_HIDDEN, cyc, to);
            checks++; if (to) begin failures++; $display("[TB] FAIL relu_timeout got=%0d cycles exp=vec_valid", cyc); end
            checks++; if (elem(0) !== (pass == 0 ? -4 : 0)) begin failures++; $display("[TB] FAIL relu_elem0 got=%0d exp=%0d", elem(0), (pass == 0 ? -4 : 0)); end
            for (int i = 0; i < N_HIDDEN; i++) begin
                checks++; if (elem(i) !== exp_vec[i]) begin failures++; $display("[TB] FAIL relu_elem[%0d] got=%0d exp=%0d", i, elem(i), exp_vec[i]); end
            end
            checks++; if (int'(sat_count) !== exp_sat) begin failures++; $display("[TB] FAIL relu_sat got=%0d exp=%0d", sat_count, exp_sat); end
        end
    endtask

    task automatic test_saturate();
        int cyc; bit to;
        fill_small();
        stim[0] = longint'(1) << 30;
        stim[1] = -(longint'(1) << 30);
        build_expected(0, 1'b0);
        pulse_start(0, 1'b0);
        stream(0, N_HIDDEN, cyc, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL sat_timeout got=%0d cycles exp=vec_valid", cyc); end
        checks++; if (elem(0) !== 32767) begin failures++; $display("[TB] FAIL sat_pos got=%0d exp=32767", elem(0)); end
        checks++; if (elem(1) !== -32768) begin failures++; $display("[TB] FAIL sat_neg got=%0d exp=-32768", elem(1)); end
        checks++; if (sat_count !== 7'd2) begin failures++; $display("[TB] FAIL sat_count got=%0d exp=2", sat_count); end
        for (int i = 0; i < N_HIDDEN; i++) begin
            checks++; if (elem(i) !== exp_vec[i]) begin failures++; $display("[TB] FAIL sat_elem[%0d] got=%0d exp=%0d", i, elem(i), exp_vec[i]); end
        end
    endtask

    task automatic test_gaps();
        int cyc; bit to;
        fill_mixed();
        build_expected(2, 1'b0);
        pulse_start(2, 1'b0);
        stream(50, N_HIDDEN, cyc, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL gaps_timeout got=%0d cycles exp=vec_valid", cyc); end
        checks++; if (addr_log.size() !== N_HIDDEN) begin failures++; $display("[TB] FAIL gaps_accepts got=%0d exp=%0d", addr_log.size(), N_HIDDEN); end
        for (int i = 0; i < addr_log.size(); i++) begin
            checks++; if (addr_log[i] !== 2*N_HIDDEN + i) begin failures++; $display("[TB] FAIL gaps_raddr[%0d] got=%0d exp=%0d", i, addr_log[i], 2*N_HIDDEN + i); end
        end
        for (int i = 0; i < N_HIDDEN; i++) begin
            checks++; if (elem(i) !== exp_vec[i]) begin failures++; $display("[TB] FAIL gaps_elem[%0d] got=%0d exp=%0d", i, elem(i), exp_vec[i]); end
        end
        checks++; if (int'(sat_count) !== exp_sat) begin failures++; $display("[TB] FAIL gaps_sat got=%0d exp=%0d", sat_count, exp_sat); end
    endtask

    task automatic test_restart();
        int cyc; bit to;
        for (int i = 0; i < N_HIDDEN; i++) stim[i] = (i % 2 == 1) ? (longint'(1) << 34) : -(longint'(1) << 34);
        pulse_start(1, 1'b0);
        stream(0, 10, cyc, to);
        checks++; if (addr_log.size() !== 10) begin failures++; $display("[TB] FAIL restart_prefix got=%0d exp=10", addr_log.size()); end
        fill_small();
        stim[5] = longint'(1) << 33;
        build_expected(0, 1'b1);
        pulse_start(0, 1'b1);
        checks++; if (sat_count !== 7'd0) begin failures++; $display("[TB] FAIL restart_sat_clear got=%0d exp=0", sat_count); end
        checks++; if (busy !== 1'b1 || vec_valid !== 1'b0) begin failures++; $display("[TB] FAIL restart_state got=busy%b/vv%b exp=busy1/vv0", busy, vec_valid); end
        checks++; if (bus.bmem_raddr !== 8'd0) begin failures++; $display("[TB] FAIL restart_raddr got=%0d exp=0", bus.bmem_raddr); end
        stream(0, N_HIDDEN, cyc, to);
        checks++; if (cyc !== N_HIDDEN + 2) begin failures++; $display("[TB] FAIL restart_latency got=%0d exp=%0d", cyc, N_HIDDEN + 2); end
        for (int i = 0; i < N_HIDDEN; i++) begin
            checks++; if (elem(i) !== exp_vec[i]) begin failures++; $display("[TB] FAIL restart_elem[%0d] got=%0d exp=%0d", i, elem(i), exp_vec[i]); end
        end
        checks++; if (int'(sat_count) !== exp_sat) begin failures++; $display("[TB] FAIL restart_sat got=%0d exp=%0d", sat_count, exp_sat); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit to;
        for (int i = 0; i < N_HIDDEN; i++) stim[i] = longint'(1) << 35;
        pulse_start(2, 1'b0);
        stream(0, 20, cyc, to);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0 || vec_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ctrl got=ready%b/busy%b/vv%b exp=0/0/0", bus.in_ready, busy, vec_valid); end
        checks++; if (sat_count !== 7'd0) begin failures++; $display("[TB] FAIL midrst_sat got=%0d exp=0", sat_count); end
        checks++; if (bus.bmem_raddr !== 8'd0) begin failures++; $display("[TB] FAIL midrst_raddr got=%0d exp=0", bus.bmem_raddr); end
        checks++; if (out_vec !== '0) begin failures++; $display("[TB] FAIL midrst_out_vec got=%h exp=0", out_vec); end
        rst_n = 1'b1;
        fill_mixed();
        build_expected(1, 1'b0);
        pulse_start(1, 1'b0);
        stream(0, N_HIDDEN, cyc, to);
        checks++; if (cyc !== N_HIDDEN + 2) begin failures++; $display("[TB] FAIL midrst_latency got=%0d exp=%0d", cyc, N_HIDDEN + 2); end
        for (int i = 0; i < N_HIDDEN; i++) begin
            checks++; if (elem(i) !== exp_vec[i]) begin failures++; $display("[TB] FAIL midrst_elem[%0d] got=%0d exp=%0d", i, elem(i), exp_vec[i]); end
        end
        checks++; if (int'(sat_count) !== exp_sat) begin failures++; $display("[TB] FAIL midrst_sat_end got=%0d exp=%0d", sat_count, exp_sat); end
    endtask

    // Test sequence.
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        start_layer  = 1'b0;
        layer_idx    = 2'd0;
        relu_en      = 1'b0;
        for (int i = 0; i < DEPTH; i++) bias_mem[i] = DATA_W'($signed($urandom) >>> 20);
        test_reset();
        test_basic();
        test_relu();
        test_saturate();
        test_gaps();
        test_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog in case the clock or a task stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
